// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending CPU stores that drains to data memory
// whenever the memory port is not taken by a load, flagging loads that hit a pending store.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DATA_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [1:0]            st_maskmode,
    input  logic                  ld_req,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    output logic                  ld_hazard,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [1:0]            mem_maskmode,
    input  logic                  drain_req,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            mode;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] hit;
    logic             unused_ld_low;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign count    = count_q;
    assign st_ready = !full && !drain_req;
    assign enq      = st_valid && st_ready;
    // Loads own the memory port, so they suppress the drain for the cycle.
    assign deq       = !empty && !ld_req;
    assign mem_write = deq;

    assign mem_address    = empty ? '0 : entries[head_q].addr;
    assign mem_write_data = empty ? '0 : entries[head_q].data;
    assign mem_maskmode   = empty ? '0 : entries[head_q].mode;

    // NOTE: entry storage has no reset; valid_q/count_q guarantee a stale entry is never presented.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail_q] <= '{addr: st_addr, data: st_data, mode: st_maskmode};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (enq) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
            if (deq) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Word-granular match against registered entries only; a same-cycle enqueue is not visible.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_q[i] &&
                     (entries[i].addr[DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2]);
        end
    end

    assign ld_hazard     = ld_req && (|hit);
    assign unused_ld_low = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the buffer.
module tb_store_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [DW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic [1:0]    st_maskmode = '0;
    logic          ld_req = 1'b0;
    logic [DW-1:0] ld_addr = '0;
    logic          ld_hazard;
    logic          mem_write;
    logic [DW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [1:0]    mem_maskmode;
    logic          drain_req = 1'b0;
    logic          empty;
    logic          full;
    logic [2:0]    count;

    store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_maskmode    (st_maskmode),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_hazard      (ld_hazard),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_maskmode   (mem_maskmode),
        .drain_req      (drain_req),
        .empty          (empty),
        .full           (full),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    m;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hazard(input logic [DW-1:0] la);
        foreach (q[i]) begin
            if (q[i].a[DW-1:2] == la[DW-1:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Compare every output with what the model says for the current inputs.
    task automatic compare_all();
        int  n;
        bit  drain;
        n     = q.size();
        drain = (n != 0) && !ld_req;
        check("count",     DW'(count),     DW'(n));
        check("empty",     DW'(empty),     DW'(n == 0));
        check("full",      DW'(full),      DW'(n == DEPTH));
        check("st_ready",  DW'(st_ready),  DW'((n < DEPTH) && !drain_req));
        check("mem_write", DW'(mem_write), DW'(drain));
        check("mem_addr",  mem_address,    (n != 0) ? q[0].a : '0);
        check("mem_data",  mem_write_data, (n != 0) ? q[0].d : '0);
        check("mem_mode",  DW'(mem_maskmode), (n != 0) ? DW'(q[0].m) : '0);
        check("ld_hazard", DW'(ld_hazard), DW'(ld_req && model_hazard(ld_addr)));
    endtask

    task automatic drive_check(input bit sv, input logic [DW-1:0] a, input logic [DW-1:0] d,
                               input logic [1:0] m, input bit lr, input logic [DW-1:0] la,
                               input bit dr);
        @(negedge clk);
        st_valid    = sv;
        st_addr     = a;
        st_data     = d;
        st_maskmode = m;
        ld_req      = lr;
        ld_addr     = la;
        drain_req   = dr;
        #1;
        compare_all();
    endtask

    task automatic tick();
        bit   acc;
        bit   drn;
        ent_t e;
        acc = st_valid && (q.size() < DEPTH) && !drain_req;
        drn = (q.size() != 0) && !ld_req;
        e   = '{a: st_addr, d: st_data, m: st_maskmode};
        @(posedge clk);
        if (reset_n) begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic step(input bit sv, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] m, input bit lr, input logic [DW-1:0] la,
                        input bit dr);
        drive_check(sv, a, d, m, lr, la, dr);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 2'b00, 0, '0, 0);
    endtask

    initial begin
        // Reset values, with a load presented to show the hazard stays low.
        ld_req  = 1'b1;
        ld_addr = 32'h10;
        #12;
        check("rst_count", DW'(count),     '0);
        check("rst_empty", DW'(empty),     DW'(1));
        check("rst_full",  DW'(full),      '0);
        check("rst_mw",    DW'(mem_write), '0);
        check("rst_haz",   DW'(ld_hazard), '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single store reaches memory the next cycle, buffer empty after that.
        step(1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, '0, 0);
        drive_check(0, '0, '0, 2'b00, 0, '0, 0);
        check("a_mw",   DW'(mem_write), DW'(1));
        check("a_addr", mem_address,    32'h10);
        check("a_data", mem_write_data, 32'hDEAD_BEEF);
        tick();
        drive_check(0, '0, '0, 2'b00, 0, '0, 0);
        check("a_empty", DW'(empty), DW'(1));
        tick();

        // Fill behind a load, fifth store refused, then FIFO-order drain.
        for (int i = 0; i < 5; i++) begin
            drive_check(1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 2'(i), 1, 32'h900, 0);
            if (i == 4) begin
                check("f_full",  DW'(full),      DW'(1));
                check("f_ready", DW'(st_ready),  '0);
                check("f_mw",    DW'(mem_write), '0);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive_check(0, '0, '0, 2'b00, 0, '0, 0);
            check("f_order", mem_address, 32'h100 + 32'(4 * i));
            check("f_drain", DW'(mem_write), DW'(1));
            tick();
        end

        // Word-granular hazard detection, including maskmode 11 forwarding.
        step(1, 32'h24, 32'h1234_5678, 2'b11, 1, 32'h0, 0);
        drive_check(0, '0, '0, 2'b00, 1, 32'h27, 0);
        check("haz_27", DW'(ld_hazard), DW'(1));
        tick();
        drive_check(0, '0, '0, 2'b00, 1, 32'h28, 0);
        check("haz_28", DW'(ld_hazard), '0);
        tick();
        idle(2);

        // Full buffer under continuous stores: pointer wrap, order preserved.
        for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(4 * i), $urandom, 2'b10, 1, '0, 0);
        for (int i = 0; i < 12; i++) step(1, 32'h300 + 32'(4 * i), $urandom, 2'($urandom), 0, '0, 0);
        idle(5);

        // Fence: three entries drain while st_ready stays low.
        for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(4 * i), $urandom, 2'b01, 1, '0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_check(1, 32'h500, 32'h55, 2'b00, 0, '0, 1);
            check("fence_rdy", DW'(st_ready), '0);
            tick();
        end
        drive_check(0, '0, '0, 2'b00, 0, '0, 0);
        check("fence_empty", DW'(empty),    DW'(1));
        check("fence_rdy1",  DW'(st_ready), DW'(1));
        tick();

        // Reset with two pending stores discards them immediately.
        for (int i = 0; i < 2; i++) step(1, 32'h600 + 32'(4 * i), $urandom, 2'b10, 1, '0, 0);
        drive_check(0, '0, '0, 2'b00, 0, '0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_mw",    DW'(mem_write), '0);
        check("mr_count", DW'(count),     '0);
        check("mr_empty", DW'(empty),     DW'(1));
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        step(1, 32'h700, 32'h77, 2'b00, 1, '0, 0);
        drive_check(0, '0, '0, 2'b00, 1, '0, 0);
        check("post_rst_acc", DW'(count), DW'(1));
        tick();
        idle(2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] la;
            la = 32'($urandom_range(0, 63));
            if (q.size() != 0 && $urandom_range(0, 1) == 1)
                la = {q[$urandom_range(0, q.size() - 1)].a[DW-1:2], 2'($urandom)};
            step($urandom_range(0, 9) < 6, 32'($urandom_range(0, 63)), $urandom, 2'($urandom),
                 $urandom_range(0, 9) < 3, la, $urandom_range(0, 9) == 0);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
